led_band_decoder: RTL and testbench

//   Receive-side decoder for the rotating holiday-light band. Samples a 16-bit LED bus,

---
 rtl/led_band_decoder.sv | 138 +++++++++++++
 tb/tb_led_band_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_band_decoder.sv
// Receive-side decoder for the rotating LED band: recovers band position/width from a
// synchronized LED bus and checks that each change is a one-step circular left rotation.
module led_band_decoder #(
  parameter int MAX_WIDTH = 8,
  parameter int PERIOD_W  = 32,
  parameter int REV_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         led_in,
  output logic                band_valid,
  output logic [3:0]          band_pos,
  output logic [3:0]          band_width,
  output logic                step_pulse,
  output logic                step_err,
  output logic [PERIOD_W-1:0] period,
  output logic [REV_W-1:0]    rev_count,
  output logic [1:0]          state
);

  // state    | meaning
  // ST_IDLE  | no band seen, waiting for a legal pattern
  // ST_LOCK  | legal band captured, no rotation step yet
  // ST_TRACK | band rotating by one position per step
  // ST_ERR   | illegal change seen; only an all-dark bus releases it
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK  = 2'd1,
    ST_TRACK = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t              state_q;
  logic [15:0]         s1_q, s_q, ref_q;
  logic [3:0]          pos_q, width_q;
  logic [PERIOD_W-1:0] cnt_q, period_q;
  logic [REV_W-1:0]    rev_q;
  logic                valid_q, step_pulse_q, step_err_q;

  logic [4:0]          edge_cnt, pop;
  logic [3:0]          dec_pos, dec_width;
  logic                legal;
  logic [15:0]         rot;
  logic [PERIOD_W-1:0] cnt_d;

  // A band's lowest bit is the lit bit whose circular lower neighbour is dark.
  always_comb begin
    edge_cnt = 5'd0;
    pop      = 5'd0;
    dec_pos  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (s_q[i] && !s_q[(i + 15) % 16]) begin
        edge_cnt = edge_cnt + 5'd1;
        dec_pos  = 4'(i);
      end
      pop = pop + {4'd0, s_q[i]};
    end
    dec_width = pop[3:0];
    legal     = (edge_cnt == 5'd1) && (pop <= 5'(MAX_WIDTH));
    rot       = {ref_q[14:0], ref_q[15]};
    cnt_d     = (&cnt_q) ? cnt_q : cnt_q + PERIOD_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q         <= '0;
      s_q          <= '0;
      ref_q        <= '0;
      pos_q        <= '0;
      width_q      <= '0;
      cnt_q        <= '0;
      period_q     <= '0;
      rev_q        <= '0;
      valid_q      <= 1'b0;
      step_pulse_q <= 1'b0;
      step_err_q   <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      s1_q         <= led_in;
      s_q          <= s1_q;
      step_pulse_q <= 1'b0;
      step_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (legal) begin
            state_q <= ST_LOCK;
            valid_q <= 1'b1;
            ref_q   <= s_q;
            pos_q   <= dec_pos;
            width_q <= dec_width;
            cnt_q   <= '0;
          end
        end
        ST_LOCK, ST_TRACK: begin
          if (s_q == ref_q) begin
            cnt_q <= cnt_d;
          end else if (s_q == 16'h0000) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end else if (s_q == rot) begin
            state_q      <= ST_TRACK;
            step_pulse_q <= 1'b1;
            period_q     <= cnt_d;
            cnt_q        <= '0;
            ref_q        <= s_q;
            pos_q        <= dec_pos;
            width_q      <= dec_width;
            if (dec_pos == 4'd0) rev_q <= rev_q + REV_W'(1);
          end else if (legal && dec_pos == pos_q && dec_width != width_q) begin
            // Width switch on the driver: re-anchor without flagging an error.
            state_q <= ST_LOCK;
            ref_q   <= s_q;
            pos_q   <= dec_pos;
            width_q <= dec_width;
            cnt_q   <= '0;
          end else begin
            state_q    <= ST_ERR;
            valid_q    <= 1'b0;
            step_err_q <= 1'b1;
          end
        end
        ST_ERR: begin
          if (s_q == 16'h0000) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign band_valid = valid_q;
  assign band_pos   = pos_q;
  assign band_width = width_q;
  assign step_pulse = step_pulse_q;
  assign step_err   = step_err_q;
  assign period     = period_q;
  assign rev_count  = rev_q;
  assign state      = state_q;

endmodule

// File: tb/tb_led_band_decoder.sv
// Scoreboard bench for led_band_decoder: stimulus queues expected output events,
// a monitor pops and compares on every state change or pulse.
module tb_led_band_decoder;

  logic        clk, rst;
  logic [15:0] led, led4;

  logic        band_valid, step_pulse, step_err;
  logic [3:0]  band_pos, band_width;
  logic [31:0] period;
  logic [7:0]  rev_count;
  logic [1:0]  state;

  logic        d4_valid, d4_sp, d4_se;
  logic [3:0]  d4_pos, d4_width;
  logic [3:0]  d4_period;
  logic [7:0]  d4_rev;
  logic [1:0]  d4_state;

  led_band_decoder dut (
    .clk(clk), .rst(rst), .led_in(led),
    .band_valid(band_valid), .band_pos(band_pos), .band_width(band_width),
    .step_pulse(step_pulse), .step_err(step_err), .period(period),
    .rev_count(rev_count), .state(state)
  );

  led_band_decoder #(.MAX_WIDTH(8), .PERIOD_W(4), .REV_W(8)) dut4 (
    .clk(clk), .rst(rst), .led_in(led4),
    .band_valid(d4_valid), .band_pos(d4_pos), .band_width(d4_width),
    .step_pulse(d4_sp), .step_err(d4_se), .period(d4_period),
    .rev_count(d4_rev), .state(d4_state)
  );

  typedef struct packed {
    logic [1:0]  st;
    logic        v;
    logic [3:0]  pos;
    logic [3:0]  wid;
    logic        sp;
    logic        se;
    logic [31:0] per;
    logic [7:0]  rev;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic void push(input logic [1:0] st, input logic v, input logic [3:0] pos,
                               input logic [3:0] wid, input logic sp, input logic se,
                               input logic [31:0] per, input logic [7:0] rev);
    ev_t e;
    e.st = st; e.v = v; e.pos = pos; e.wid = wid;
    e.sp = sp; e.se = se; e.per = per; e.rev = rev;
    exp_q.push_back(e);
  endfunction

  // Monitor: one comparison per observed output event.
  initial begin
    logic [1:0] prev_st;
    ev_t act, e;
    prev_st = 2'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_st = state;
      end else if (state != prev_st || step_pulse || step_err) begin
        act = '{st: state, v: band_valid, pos: band_pos, wid: band_width,
                sp: step_pulse, se: step_err, per: period, rev: rev_count};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL event: unexpected st=%0d v=%0b pos=%0d w=%0d sp=%0b se=%0b per=%0d rev=%0d, none expected",
                   act.st, act.v, act.pos, act.wid, act.sp, act.se, act.per, act.rev);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_bad++;
            $display("FAIL event @%0t: got st=%0d v=%0b pos=%0d w=%0d sp=%0b se=%0b per=%0d rev=%0d, want st=%0d v=%0b pos=%0d w=%0d sp=%0b se=%0b per=%0d rev=%0d",
                     $time, act.st, act.v, act.pos, act.wid, act.sp, act.se, act.per, act.rev,
                     e.st, e.v, e.pos, e.wid, e.sp, e.se, e.per, e.rev);
          end
        end
        prev_st = state;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] bad_pats [3];
    bad_pats[0] = 16'h0505;
    bad_pats[1] = 16'hFFFF;
    bad_pats[2] = 16'h01FF;

    rst = 1'b1; led = 16'h0001; led4 = 16'h0000;
    tick(2);
    chk("rst state", 32'(state), 0);
    chk("rst valid", 32'(band_valid), 0);
    chk("rst pos", 32'(band_pos), 0);
    chk("rst width", 32'(band_width), 0);
    chk("rst step_pulse", 32'(step_pulse), 0);
    chk("rst step_err", 32'(step_err), 0);
    chk("rst period", period, 0);
    chk("rst rev", 32'(rev_count), 0);

    push(2'd1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 32'd0, 8'd0);
    rst = 1'b0;
    tick(2);
    chk("lock latency 2clk", 32'(state), 0);
    tick(1);
    chk("lock latency 3clk", 32'(state), 1);
    chk("lock valid", 32'(band_valid), 1);

    // Width switch 1->3 at pos 0 stays LOCK silently, then 16 rotations.
    led = 16'h0007;
    tick(10);
    v = 16'h0007;
    for (int k = 1; k <= 16; k++) begin
      v = {v[14:0], v[15]};
      push(2'd2, 1'b1, 4'(k % 16), 4'd3, 1'b1, 1'b0, 32'd10, (k == 16) ? 8'd1 : 8'd0);
      led = v;
      tick(10);
    end

    push(2'd0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 32'd10, 8'd1);
    led = 16'h0000; tick(10);
    push(2'd1, 1'b1, 4'd3, 4'd4, 1'b0, 1'b0, 32'd10, 8'd1);
    led = 16'h0078; tick(10);
    push(2'd2, 1'b1, 4'd4, 4'd4, 1'b1, 1'b0, 32'd10, 8'd1);
    led = 16'h00F0; tick(10);
    push(2'd1, 1'b1, 4'd4, 4'd2, 1'b0, 1'b0, 32'd10, 8'd1);
    led = 16'h0030; tick(10);
    push(2'd2, 1'b1, 4'd5, 4'd2, 1'b1, 1'b0, 32'd10, 8'd1);
    led = 16'h0060; tick(10);

    // Wrap 0x8001 -> 0x0003, then a two-position jump.
    push(2'd0, 1'b0, 4'd5, 4'd2, 1'b0, 1'b0, 32'd10, 8'd1);
    led = 16'h0000; tick(10);
    push(2'd1, 1'b1, 4'd15, 4'd2, 1'b0, 1'b0, 32'd10, 8'd1);
    led = 16'h8001; tick(10);
    push(2'd2, 1'b1, 4'd0, 4'd2, 1'b1, 1'b0, 32'd10, 8'd2);
    led = 16'h0003; tick(10);
    push(2'd3, 1'b0, 4'd0, 4'd2, 1'b0, 1'b1, 32'd10, 8'd2);
    led = 16'h000C; tick(3);
    chk("step_err asserted", 32'(step_err), 1);
    tick(1);
    chk("step_err one cycle", 32'(step_err), 0);
    chk("err holds", 32'(state), 3);
    tick(6);
    led = 16'h0018; tick(10);
    chk("err on legal band", 32'(state), 3);
    push(2'd0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, 32'd10, 8'd2);
    led = 16'h0000; tick(10);

    for (int i = 0; i < 3; i++) begin
      led = bad_pats[i]; tick(10);
      chk("illegal stays idle", 32'(state), 0);
      chk("illegal not valid", 32'(band_valid), 0);
    end
    push(2'd1, 1'b1, 4'd0, 4'd8, 1'b0, 1'b0, 32'd10, 8'd2);
    led = 16'h00FF; tick(10);
    push(2'd0, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0, 32'd10, 8'd2);
    led = 16'h0000; tick(10);

    // Narrow period counter saturates over a 20-clock step.
    led4 = 16'h0001; tick(20);
    led4 = 16'h0002; tick(4);
    chk("d4 period saturated", 32'(d4_period), 32'hF);
    chk("d4 state track", 32'(d4_state), 2);

    push(2'd1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 32'd10, 8'd2);
    led = 16'h0001; tick(5);
    push(2'd2, 1'b1, 4'd1, 4'd1, 1'b1, 1'b0, 32'd5, 8'd2);
    led = 16'h0002; tick(6);
    rst = 1'b1;
    #1;
    chk("async rst state", 32'(state), 0);
    chk("async rst valid", 32'(band_valid), 0);
    chk("async rst pos", 32'(band_pos), 0);
    chk("async rst width", 32'(band_width), 0);
    chk("async rst period", period, 0);
    chk("async rst rev", 32'(rev_count), 0);
    chk("async rst d4 state", 32'(d4_state), 0);
    chk("async rst d4 period", 32'(d4_period), 0);
    tick(1);
    push(2'd1, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 32'd0, 8'd0);
    rst = 1'b0;
    tick(2);
    chk("relock latency 2clk", 32'(state), 0);
    tick(1);
    chk("relock latency 3clk", 32'(state), 1);
    tick(5);

    chk("leftover expected events", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
